// File: rtl/char_state_handler_if.sv
// char_state_handler_if: tick/button inputs and state outputs of the character state machine
interface char_state_handler_if;
    logic       frame_tick;
    logic       btn_left;
    logic       btn_right;
    logic       btn_attack;
    logic [3:0] state;
    logic       attack_active;
    logic       busy;
    logic [4:0] phase_cnt;
    modport master (
        output frame_tick, btn_left, btn_right, btn_attack,
        input  state, attack_active, busy, phase_cnt
    );
    modport slave (
        input  frame_tick, btn_left, btn_right, btn_attack,
        output state, attack_active, busy, phase_cnt
    );
endinterface

// File: rtl/char_state_handler.sv
// char_state_handler: frame-gated movement/attack state machine producing the 4-bit character state
module char_state_handler #(
    parameter bit         FORWARD_RIGHT       = 1'b1,
    parameter logic [4:0] ATK_START_FRAMES    = 5'd5,
    parameter logic [4:0] ATK_ACTIVE_FRAMES   = 5'd2,
    parameter logic [4:0] ATK_RECOVERY_FRAMES = 5'd16,
    parameter logic [4:0] DIR_START_FRAMES    = 5'd4,
    parameter logic [4:0] DIR_ACTIVE_FRAMES   = 5'd3,
    parameter logic [4:0] DIR_RECOVERY_FRAMES = 5'd15
) (
    input logic clk,
    input logic rst,
    char_state_handler_if.slave bus
);
    typedef enum logic [3:0] {
        S_IDLE                = 4'd0,
        S_LEFT                = 4'd1,
        S_RIGHT               = 4'd2,
        S_ATTACK_START        = 4'd3,
        S_ATTACK_ACTIVE       = 4'd4,
        S_ATTACK_RECOVERY     = 4'd5,
        S_ATTACK_DIR_START    = 4'd6,
        S_ATTACK_DIR_ACTIVE   = 4'd7,
        S_ATTACK_DIR_RECOVERY = 4'd8
    } state_t;

    state_t     r_state;
    logic [4:0] r_cnt;
    logic       r_atk_prev;
    logic       r_active;
    logic       r_busy;

    state_t     w_next;
    logic [4:0] w_next_cnt;
    logic [4:0] w_len;
    logic       w_edge;
    logic       w_fwd;
    logic       w_last;
    logic       w_in_attack;
    logic       w_illegal;

    assign w_edge      = bus.btn_attack & ~r_atk_prev;
    assign w_fwd       = FORWARD_RIGHT ? bus.btn_right : bus.btn_left;
    assign w_in_attack = (r_state >= S_ATTACK_START) && (r_state <= S_ATTACK_DIR_RECOVERY);
    assign w_illegal   = r_state > S_ATTACK_DIR_RECOVERY;
    assign w_last      = r_cnt == w_len - 5'd1;

    // frame length of the phase currently being counted
    always_comb begin
        w_len = (r_state == S_ATTACK_START)        ? ATK_START_FRAMES    :
                (r_state == S_ATTACK_ACTIVE)       ? ATK_ACTIVE_FRAMES   :
                (r_state == S_ATTACK_RECOVERY)     ? ATK_RECOVERY_FRAMES :
                (r_state == S_ATTACK_DIR_START)    ? DIR_START_FRAMES    :
                (r_state == S_ATTACK_DIR_ACTIVE)   ? DIR_ACTIVE_FRAMES   :
                (r_state == S_ATTACK_DIR_RECOVERY) ? DIR_RECOVERY_FRAMES : 5'd1;
    end

    // next state: movement states re-evaluate buttons, attack phases run their frame counters
    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE, S_LEFT, S_RIGHT:
                w_next = w_edge ? (w_fwd ? S_ATTACK_DIR_START : S_ATTACK_START) :
                         (bus.btn_left & ~bus.btn_right) ? S_LEFT :
                         (bus.btn_right & ~bus.btn_left) ? S_RIGHT : S_IDLE;
            S_ATTACK_START:        w_next = w_last ? S_ATTACK_ACTIVE     : S_ATTACK_START;
            S_ATTACK_ACTIVE:       w_next = w_last ? S_ATTACK_RECOVERY   : S_ATTACK_ACTIVE;
            S_ATTACK_RECOVERY:     w_next = w_last ? S_IDLE              : S_ATTACK_RECOVERY;
            S_ATTACK_DIR_START:    w_next = w_last ? S_ATTACK_DIR_ACTIVE : S_ATTACK_DIR_START;
            S_ATTACK_DIR_ACTIVE:   w_next = w_last ? S_ATTACK_DIR_RECOVERY : S_ATTACK_DIR_ACTIVE;
            S_ATTACK_DIR_RECOVERY: w_next = w_last ? S_IDLE              : S_ATTACK_DIR_RECOVERY;
            default:               w_next = S_IDLE;
        endcase
        w_next_cnt = (w_in_attack && !w_last) ? r_cnt + 5'd1 : 5'd0;
    end

    // state and its decoded flags advance together on ticks; illegal codes recover without waiting for one
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 5'd0;
            r_atk_prev <= 1'b0;
            r_active   <= 1'b0;
            r_busy     <= 1'b0;
        end else if (bus.frame_tick || w_illegal) begin
            r_state  <= w_next;
            r_cnt    <= w_next_cnt;
            r_active <= (w_next == S_ATTACK_ACTIVE) || (w_next == S_ATTACK_DIR_ACTIVE);
            r_busy   <= (w_next >= S_ATTACK_START) && (w_next <= S_ATTACK_DIR_RECOVERY);
            if (bus.frame_tick) r_atk_prev <= bus.btn_attack;
        end
    end

    assign bus.state         = r_state;
    assign bus.phase_cnt     = r_cnt;
    assign bus.attack_active = r_active;
    assign bus.busy          = r_busy;
endmodule

// File: tb/tb_char_state_handler.sv
// tb_char_state_handler: vector table, attack sequences and random stimulus against a frame-timeline model
module tb_char_state_handler;
    logic clk = 1'b0;
    logic rst, tick, bl, br, ba;
    int   ncmp = 0;
    int   nerr = 0;

    char_state_handler_if if0 ();
    char_state_handler_if if1 ();

    assign if0.frame_tick = tick;
    assign if0.btn_left   = bl;
    assign if0.btn_right  = br;
    assign if0.btn_attack = ba;
    assign if1.frame_tick = tick;
    assign if1.btn_left   = bl;
    assign if1.btn_right  = br;
    assign if1.btn_attack = ba;

    char_state_handler u0 (.clk(clk), .rst(rst), .bus(if0));
    char_state_handler #(.FORWARD_RIGHT(1'b0)) u1 (.clk(clk), .rst(rst), .bus(if1));

    always #5 clk = ~clk;

    logic [10:0] g0, g1;
    assign g0 = {if0.state, if0.phase_cnt, if0.attack_active, if0.busy};
    assign g1 = {if1.state, if1.phase_cnt, if1.attack_active, if1.busy};

    // model: attack as a frame index into a start/active/recovery timeline, else last movement
    int mf [2];
    bit mk [2];
    int mv [2];
    bit mp;

    function automatic logic [10:0] pk(input int s, input int c, input bit a, input bit b);
        return {4'(s), 5'(c), a, b};
    endfunction

    function automatic logic [10:0] timeline(input bit dir, input int f);
        int s, a, base;
        s    = dir ? 4 : 5;
        a    = dir ? 3 : 2;
        base = dir ? 6 : 3;
        if (f < s) return pk(base, f, 1'b0, 1'b1);
        if (f < s + a) return pk(base + 1, f - s, 1'b1, 1'b1);
        return pk(base + 2, f - s - a, 1'b0, 1'b1);
    endfunction

    function automatic logic [10:0] mexp(input int k);
        return (mf[k] < 0) ? pk(mv[k], 0, 1'b0, 1'b0) : timeline(mk[k], mf[k]);
    endfunction

    task automatic chk(input string nm, input logic [10:0] got, input logic [10:0] exp);
        ncmp++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s at %0t: got state=%h cnt=%0d act=%b busy=%b, expected state=%h cnt=%0d act=%b busy=%b",
                     nm, $time, got[10:7], got[6:2], got[1], got[0], exp[10:7], exp[6:2], exp[1], exp[0]);
        end
    endtask

    task automatic cyc(input bit r_, input bit t_, input bit l_, input bit rr_, input bit a_);
        bit e;
        rst = r_; tick = t_; bl = l_; br = rr_; ba = a_;
        if (r_) begin
            mf = '{-1, -1}; mv = '{0, 0}; mp = 1'b0;
        end else if (t_) begin
            e  = a_ & ~mp;
            mp = a_;
            for (int k = 0; k < 2; k++) begin
                if (mf[k] >= 0) begin
                    mf[k]++;
                    if (mf[k] == (mk[k] ? 22 : 23)) begin mf[k] = -1; mv[k] = 0; end
                end else if (e) begin
                    mf[k] = 0;
                    mk[k] = (k == 0) ? rr_ : l_;
                end else
                    mv[k] = (l_ & ~rr_) ? 1 : (rr_ & ~l_) ? 2 : 0;
            end
        end
        @(posedge clk);
        #1;
        chk("model_fr1", g0, mexp(0));
        chk("model_fr0", g1, mexp(1));
    endtask

    task automatic tk(input bit l_, input bit r_, input bit a_);
        cyc(1'b0, 1'b0, l_, r_, a_);
        cyc(1'b0, 1'b1, l_, r_, a_);
    endtask

    typedef struct {
        bit         r, t, l, rt, a;
        logic [3:0] st;
        logic [4:0] cnt;
        bit         act, busy;
    } vec_t;
    vec_t tbl [11];

    initial begin
        rst = 1'b1; tick = 1'b0; bl = 1'b0; br = 1'b0; ba = 1'b0;
        mf = '{-1, -1}; mk = '{1'b0, 1'b0}; mv = '{0, 0}; mp = 1'b0;
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 5'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 5'd0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 5'd0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 5'd0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 5'd0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 5'd0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0};
        for (int i = 0; i < 11; i++) begin
            cyc(tbl[i].r, tbl[i].t, tbl[i].l, tbl[i].rt, tbl[i].a);
            chk($sformatf("vec%0d", i), g0, {tbl[i].st, tbl[i].cnt, tbl[i].act, tbl[i].busy});
        end
        // neutral attack: 5 start, 2 active, 16 recovery, then idle
        for (int i = 0; i < 24; i++) begin
            tk(1'b0, 1'b0, i == 0);
            chk("neutral", g0, (i == 23) ? pk(0, 0, 1'b0, 1'b0) :
                               (i < 5) ? pk(3, i, 1'b0, 1'b1) :
                               (i < 7) ? pk(4, i - 5, 1'b1, 1'b1) : pk(5, i - 7, 1'b0, 1'b1));
        end
        // right held + press: directional on the right-facing unit, neutral on the left-facing one
        for (int i = 0; i < 24; i++) begin
            tk(1'b0, 1'b1, i == 0);
            chk("dir_fr1", g0, (i == 23) ? pk(2, 0, 1'b0, 1'b0) : (i == 22) ? pk(0, 0, 1'b0, 1'b0) :
                               (i < 4) ? pk(6, i, 1'b0, 1'b1) :
                               (i < 7) ? pk(7, i - 4, 1'b1, 1'b1) : pk(8, i - 7, 1'b0, 1'b1));
            chk("dir_fr0", g1, (i == 23) ? pk(0, 0, 1'b0, 1'b0) :
                               (i < 5) ? pk(3, i, 1'b0, 1'b1) :
                               (i < 7) ? pk(4, i - 5, 1'b1, 1'b1) : pk(5, i - 7, 1'b0, 1'b1));
        end
        tk(1'b0, 1'b0, 1'b0);
        // held attack never re-triggers; release and re-press does
        for (int i = 0; i < 30; i++) begin
            tk(1'b0, 1'b0, 1'b1);
            if (i == 0) chk("held_start", g0, pk(3, 0, 1'b0, 1'b1));
            if (i >= 23) chk("held_idle", g0, pk(0, 0, 1'b0, 1'b0));
        end
        tk(1'b0, 1'b0, 1'b0);
        tk(1'b0, 1'b0, 1'b1);
        chk("repress", g0, pk(3, 0, 1'b0, 1'b1));
        for (int i = 0; i < 23; i++) tk(1'b0, 1'b0, 1'b0);
        // reset during the active phase
        tk(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) tk(1'b0, 1'b0, 1'b0);
        chk("pre_rst_active", g0, pk(4, 0, 1'b1, 1'b1));
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_mid", g0, pk(0, 0, 1'b0, 1'b0));
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("rst_tick", g0, pk(0, 0, 1'b0, 1'b0));
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("post_rst", g0, pk(0, 0, 1'b0, 1'b0));
        // random traffic checked every cycle against the model
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 2) != 0, 1'($urandom),
                1'($urandom), ($urandom_range(0, 3) == 0) ? ~ba : ba);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/char_state_handler.md
# char_state_handler

Per-character action state machine that turns synchronized button inputs into the 4-bit character state consumed by the position handler and sprite/hitbox logic. It sequences movement (idle/left/right) and the two attack types (neutral and directional) through startup, active and recovery phases. Each phase is counted in frames, and all state changes are gated by a one-cycle frame tick.

## Interface
- FORWARD_RIGHT, 1'b1: 1 = character faces right, so forward is btn_right; 0 = forward is btn_left.
- ATK_START_FRAMES, 5'd5: neutral attack startup length, in frames.
- ATK_ACTIVE_FRAMES, 5'd2: neutral attack active length, in frames.
- ATK_RECOVERY_FRAMES, 5'd16: neutral attack recovery length, in frames.
- DIR_START_FRAMES, 5'd4: directional attack startup length, in frames.
- DIR_ACTIVE_FRAMES, 5'd3: directional attack active length, in frames.
- DIR_RECOVERY_FRAMES, 5'd15: directional attack recovery length, in frames.
- All frame counts are legal in the range 1..31.

- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- frame_tick  in  1  one-cycle pulse, once per video frame
- btn_left  in  1  level input; already synchronized and debounced
- btn_right  in  1  level input; already synchronized and debounced
- btn_attack  in  1  level input; already synchronized and debounced
- state  out  4  current state, registered
- attack_active  out  1  1 while state is S_ATTACK_ACTIVE or S_ATTACK_DIR_ACTIVE; registered
- busy  out  1  1 in any attack state (0011..1000); registered
- phase_cnt  out  5  frames already elapsed in the current attack phase; 0 in movement states

## Operation
- State encoding is fixed and shared with the position handler:
  - IDLE 0000, LEFT 0001, RIGHT 0010
  - ATTACK_START 0011, ATTACK_ACTIVE 0100, ATTACK_RECOVERY 0101
  - ATTACK_DIR_START 0110, ATTACK_DIR_ACTIVE 0111, ATTACK_DIR_RECOVERY 1000
  - Codes 1001..1111 are illegal. If reached, the FSM returns to IDLE with phase_cnt 0 on the next clk.
- All registers hold when frame_tick=0. Every evaluation below happens only on clk edges where frame_tick=1.
- atk_edge = btn_attack & ~atk_prev. atk_prev is loaded with btn_attack on every tick, in every state. A held attack button therefore never re-triggers, including across recovery.
- Movement states (IDLE/LEFT/RIGHT), priority order:
  1. atk_edge with forward button held -> ATTACK_DIR_START.
  2. atk_edge otherwise -> ATTACK_START.
  3. btn_left & ~btn_right -> LEFT.
  4. btn_right & ~btn_left -> RIGHT.
  5. Both or neither -> IDLE.
- A movement state is re-evaluated on every tick, so a movement state lasts exactly one frame per evaluation.
- Attack phases:
  - On entry to any phase, phase_cnt=0.
  - On each tick, if phase_cnt == N-1 (N = that phase's frame count), advance to the next phase with phase_cnt=0. Otherwise increment phase_cnt.
  - Phase order is START -> ACTIVE -> RECOVERY -> IDLE, for both attack types.
  - RECOVERY always exits to IDLE. Movement resumes on the following tick.
- While busy, all button inputs are ignored except for the atk_prev update.
- Each attack therefore occupies exactly START+ACTIVE+RECOVERY frames. With defaults this is 23 neutral and 22 directional, followed by at least 1 frame in IDLE.

## Timing
- Reset: state=IDLE, phase_cnt=0, atk_prev=0, attack_active=0, busy=0. rst has priority over frame_tick and applies mid-attack as well.
- Latency: outputs change on the clk edge that samples frame_tick=1. They are visible in the cycle after the tick and hold until the next tick.
- attack_active and busy are decoded from the next-state value and registered together with state, so they are never skewed from state.
- Inputs are sampled only at tick edges. Button pulses shorter than the gap between ticks that do not overlap a tick are lost by design.

## Test plan
- Reset, then hold btn_right for 3 ticks, then release -> state reads 0010 for 3 frames, then 0000; busy=0 throughout.
- Hold btn_left and btn_right together for 2 ticks -> state stays 0000.
- Attack press with no direction at tick 0, defaults -> state sequence:
  - 0011 for 5 frames, phase_cnt 0..4
  - 0100 for 2 frames, attack_active=1
  - 0101 for 16 frames
  - then 0000
- Hold btn_right and press attack (FORWARD_RIGHT=1) -> state 0110 for 4 frames, 0111 for 3, 1000 for 15, then 0000. Repeat with FORWARD_RIGHT=0 -> neutral sequence.
- Hold btn_attack continuously through a full attack -> no second attack starts. Releasing and re-pressing after return to IDLE triggers a new one.
- Assert rst during ATTACK_ACTIVE -> next cycle shows state=0000, phase_cnt=0, attack_active=0, busy=0. Ticks with rst=1 do not advance the FSM.
